digit_entry: RTL and testbench
==============================

Name: digit_entry

Overview:
- Keypad-side number assembler that sits directly upstream of the operand buffer.
- Synchronizes raw key levels and detects key presses.
- Builds a signed two-digit decimal operand and presents it two ways: as a sign+BCD display word (digit) and as a 9-bit two's-complement value (digit_con).
- Issues a one-cycle store_digit strobe each time the operand changes, so the operand buffer can capture both words.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in the input synchronizer for every raw key input. Minimum 2.

Ports:
- clk  input  1  system clock
- nrst  input  1  reset, asynchronous, active-low
- key_num  input  10  raw decimal key levels; bit i = key "i"; asynchronous to clk
- key_neg  input  1  raw sign-toggle key level
- key_clr  input  1  raw clear key level
- enter  input  1  synchronous one-cycle enter strobe, shared with the operand buffer
- digit  output  9  {sign, tens BCD[7:4], ones BCD[3:0]} display word
- digit_con  output  9  two's-complement operand value, range -99..+99
- store_digit  output  1  one-cycle strobe; digit and digit_con are valid in the same cycle
- entry_full  output  1  level; high when two significant digits are held

Behaviour:
- Reset:
  - Asynchronous, active-low; clock is clk.
  - All synchronizer and edge-detect flops clear to 0.
  - digit=0, digit_con=0, store_digit=0, entry_full=0, internal sign=0, state=EMPTY.
  - Reset asserted mid-entry discards the partial operand. No strobe is issued on reset release.
- Input path:
  - Each of the 12 raw keys passes through a SYNC_STAGES-deep synchronizer, then a rising-edge detector (synced & ~synced_prev).
  - A press is one edge pulse. Holding a key produces no repeats.
- Event priority within one cycle: clear > enter > neg > digit key.
  - Lower-priority events in the same cycle are dropped.
  - Two or more digit-key edges in the same cycle count as an invalid chord: ignored, no strobe.
- State machine (count of significant digits):
  - EMPTY: digit d, d≠0 -> ones=d, tens=0, go to ONE. Digit 0 -> value stays 0, stay in EMPTY (leading zeros take no slot), strobe still issued.
  - ONE: digit d -> tens=ones, ones=d, go to FULL.
  - FULL: digit key ignored, no strobe, state held. entry_full=1 only in FULL.
  - neg in any state: toggle sign, strobe. State unchanged. Negative zero is allowed (digit[8]=1, digit_con=0).
  - clear in any state: tens=ones=0, sign=0, go to EMPTY, strobe with zero values (clears the downstream display).
  - enter in any state: tens=ones=0, sign=0, go to EMPTY, no strobe (downstream clears itself on enter).
- Output timing:
  - digit, digit_con, store_digit and entry_full are all registered and update on the same edge.
  - store_digit is high for exactly one cycle alongside the new values.
  - Latency: a raw key first high at setup of edge k yields store_digit high in the cycle after edge k+SYNC_STAGES (3 edges for the default).
  - Back-to-back presses on consecutive cycles each produce their own strobe.
- Arithmetic:
  - mag = tens*10 + ones (7 bits, 0..99).
  - digit_con = sign ? (~{2'b0,mag} + 1) : {2'b0,mag}, 9-bit two's complement.
  - digit[7:0] is always valid BCD.

Test Plan:
- Reset, press key 4, release, press key 7 -> two strobes; after the second, digit=0x047, digit_con=0x02F, entry_full=1.
- From 47, press neg -> strobe, digit=0x147, digit_con=0x1D1 (-47); press neg again -> digit=0x047, digit_con=0x02F.
- From FULL 47, press key 5 -> no strobe, outputs unchanged; then press clear -> strobe, digit=0, digit_con=0, entry_full=0.
- Press 0, 0, then 9 -> strobes each time; final digit=0x009, entry_full=0 (leading zeros ignored).
- key_num bits 3 and 5 rising in the same cycle -> no strobe. Press 2 with enter pulsed while the edge is detected -> enter wins, no strobe, state EMPTY. Next press 8 -> digit=0x008.
- Enter 6, negate (digit_con=0x1FA), assert nrst mid-hold of key 1 -> all outputs 0 immediately. After release with key 1 still held -> no strobe until release and re-press.

Source files
------------

// File: rtl/digit_entry.sv
// digit_entry: keypad number assembler producing a signed two-digit operand
// as a sign+BCD display word and a 9-bit two's-complement value.
module digit_entry #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [9:0] key_num,
   input  logic       key_neg,
   input  logic       key_clr,
   input  logic       enter,
   output logic [8:0] digit,
   output logic [8:0] digit_con,
   output logic       store_digit,
   output logic       entry_full
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0][11:0] sync;
   logic [11:0] prev, ev;
   logic [SYNC_STAGES:0] warm;
   logic sign, sign_n, strobe_n, single;
   logic [3:0] tens, ones, tens_n, ones_n, d;
   logic [6:0] mag;
   logic [8:0] con_n;

   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         sync <= '0;
         prev <= '0;
         warm <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], {key_clr, key_neg, key_num}};
         prev <= sync[SYNC_STAGES-1];
         warm <= {warm[SYNC_STAGES-1:0], 1'b1};
      end

   // edges are masked until the pipe has settled, so keys held across reset count as already pressed
   assign ev = warm[SYNC_STAGES] ? sync[SYNC_STAGES-1] & ~prev : '0;
   assign single = (ev[9:0] != '0) && ((ev[9:0] & (ev[9:0] - 10'd1)) == '0);

   always_comb begin
      d = '0;
      for (int i = 0; i < 10; i++)
         if (ev[i]) d = 4'(i);
   end

   always_comb begin
      state_n = state;
      sign_n = sign;
      tens_n = tens;
      ones_n = ones;
      strobe_n = 1'b0;
      if (ev[11] || enter) begin
         state_n = EMPTY;
         sign_n = 1'b0;
         tens_n = '0;
         ones_n = '0;
         strobe_n = ev[11];
      end else if (ev[10]) begin
         sign_n = ~sign;
         strobe_n = 1'b1;
      end else if (single && state != FULL) begin
         state_n = state == ONE ? FULL : (d != '0 ? ONE : EMPTY);
         tens_n = state == ONE ? ones : 4'd0;
         ones_n = d;
         strobe_n = 1'b1;
      end
      mag = {tens_n, 3'b0} + {2'b0, tens_n, 1'b0} + {3'b0, ones_n};
      con_n = sign_n ? ~{2'b0, mag} + 9'd1 : {2'b0, mag};
   end

   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         state <= EMPTY;
         sign <= 1'b0;
         tens <= '0;
         ones <= '0;
         digit_con <= '0;
         store_digit <= 1'b0;
      end else begin
         state <= state_n;
         sign <= sign_n;
         tens <= tens_n;
         ones <= ones_n;
         digit_con <= con_n;
         store_digit <= strobe_n;
      end

   assign digit = {sign, tens, ones};
   assign entry_full = state == FULL;
endmodule

// File: tb/tb_digit_entry.sv
// tb_digit_entry: directed vector table plus randomized key traffic checked
// against a delay-line and arithmetic reference model of digit_entry.
module tb_digit_entry;
   localparam int S = 2;
   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic [9:0] key_num = '0;
   logic key_neg = 1'b0, key_clr = 1'b0, enter = 1'b0;
   logic [8:0] digit, digit_con;
   logic store_digit, entry_full;

   digit_entry #(.SYNC_STAGES(S)) dut (
      .clk(clk), .nrst(nrst), .key_num(key_num), .key_neg(key_neg),
      .key_clr(key_clr), .enter(enter), .digit(digit), .digit_con(digit_con),
      .store_digit(store_digit), .entry_full(entry_full)
   );

   always #5 clk = ~clk;

   int passed = 0, total = 0, strobes = 0;
   int m_n = 0, m_t = 0, m_o = 0;
   bit m_s = 0, m_strobe = 0;
   logic [11:0] hq[$];

   typedef struct {
      logic [9:0] num;
      logic neg, clr, ent;
      logic [8:0] dig, con;
      logic full;
      int stb;
   } vec_t;
   vec_t tbl[15];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [8:0] exp_digit();
      return {m_s, 4'(m_t), 4'(m_o)};
   endfunction

   function automatic logic [8:0] exp_con();
      int mag = m_t * 10 + m_o;
      int sv = m_s ? -mag : mag;
      return 9'(sv);
   endfunction

   function automatic void model_clear();
      hq.delete();
      m_n = 0; m_t = 0; m_o = 0; m_s = 0; m_strobe = 0;
   endfunction

   // a raw level reaches the edge detector S edges after it is sampled
   task automatic step(input logic [11:0] raw, input logic en);
      logic [11:0] ev;
      int e, d;
      hq.push_back(raw);
      e = hq.size();
      ev = (e >= S + 2) ? (hq[e-1-S] & ~hq[e-2-S]) : 12'd0;
      m_strobe = 0;
      if (ev[11] || en) begin
         m_n = 0; m_t = 0; m_o = 0; m_s = 0;
         m_strobe = ev[11];
      end else if (ev[10]) begin
         m_s = !m_s;
         m_strobe = 1;
      end else if ($countones(ev[9:0]) == 1 && m_n < 2) begin
         d = 0;
         for (int i = 0; i < 10; i++) if (ev[i]) d = i;
         if (m_n == 1) begin
            m_t = m_o;
            m_n = 2;
         end else m_n = (d != 0) ? 1 : 0;
         m_o = d;
         m_strobe = 1;
      end
   endtask

   task automatic cyc(input logic [9:0] n, input logic ng, input logic cl, input logic en);
      key_num = n; key_neg = ng; key_clr = cl; enter = en;
      @(posedge clk);
      step({cl, ng, n}, en);
      #1;
      chk("cycle", {12'd0, store_digit, entry_full, digit, digit_con},
          {12'd0, m_strobe, m_n == 2, exp_digit(), exp_con()});
      if (store_digit) strobes++;
   endtask

   initial begin
      logic [9:0] n;
      int r;
      tbl[0]  = '{10'h010, 0, 0, 0, 9'h004, 9'h004, 0, 1};
      tbl[1]  = '{10'h080, 0, 0, 0, 9'h047, 9'h02F, 1, 1};
      tbl[2]  = '{10'h000, 1, 0, 0, 9'h147, 9'h1D1, 1, 1};
      tbl[3]  = '{10'h000, 1, 0, 0, 9'h047, 9'h02F, 1, 1};
      tbl[4]  = '{10'h020, 0, 0, 0, 9'h047, 9'h02F, 1, 0};
      tbl[5]  = '{10'h000, 0, 1, 0, 9'h000, 9'h000, 0, 1};
      tbl[6]  = '{10'h001, 0, 0, 0, 9'h000, 9'h000, 0, 1};
      tbl[7]  = '{10'h001, 0, 0, 0, 9'h000, 9'h000, 0, 1};
      tbl[8]  = '{10'h200, 0, 0, 0, 9'h009, 9'h009, 0, 1};
      tbl[9]  = '{10'h028, 0, 0, 0, 9'h009, 9'h009, 0, 0};
      tbl[10] = '{10'h004, 0, 0, 1, 9'h000, 9'h000, 0, 0};
      tbl[11] = '{10'h100, 0, 0, 0, 9'h008, 9'h008, 0, 1};
      tbl[12] = '{10'h000, 0, 1, 0, 9'h000, 9'h000, 0, 1};
      tbl[13] = '{10'h040, 0, 0, 0, 9'h006, 9'h006, 0, 1};
      tbl[14] = '{10'h000, 1, 0, 0, 9'h106, 9'h1FA, 0, 1};

      #1;
      model_clear();
      chk("reset", {12'd0, store_digit, entry_full, digit, digit_con}, 32'd0);
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      repeat (6) cyc(0, 0, 0, 0);

      foreach (tbl[k]) begin
         strobes = 0;
         for (int i = 0; i < 6; i++)
            cyc(i < 2 ? tbl[k].num : 10'd0, i < 2 && tbl[k].neg, i < 2 && tbl[k].clr, tbl[k].ent && i == 2);
         chk($sformatf("vec%0d digit", k), {23'd0, digit}, {23'd0, tbl[k].dig});
         chk($sformatf("vec%0d digit_con", k), {23'd0, digit_con}, {23'd0, tbl[k].con});
         chk($sformatf("vec%0d entry_full", k), {31'd0, entry_full}, {31'd0, tbl[k].full});
         chk($sformatf("vec%0d strobes", k), strobes, tbl[k].stb);
      end

      // reset asserted while key 1 is held, then released with the key still down
      repeat (4) cyc(10'h002, 0, 0, 0);
      #2 nrst = 1'b0;
      #1;
      model_clear();
      chk("async reset", {12'd0, store_digit, entry_full, digit, digit_con}, 32'd0);
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      strobes = 0;
      repeat (8) cyc(10'h002, 0, 0, 0);
      chk("held across reset strobes", strobes, 0);
      repeat (2) cyc(0, 0, 0, 0);
      strobes = 0;
      repeat (2) cyc(10'h002, 0, 0, 0);
      repeat (4) cyc(0, 0, 0, 0);
      chk("re-press strobes", strobes, 1);
      chk("re-press digit", {23'd0, digit}, 32'h001);

      n = '0;
      for (int c = 0; c < 2000; c++) begin
         r = $urandom_range(0, 99);
         if (r >= 30)
            n = r < 60 ? 10'd0 :
                r < 85 ? 10'(1 << $urandom_range(0, 9)) :
                10'((1 << $urandom_range(0, 9)) | (1 << $urandom_range(0, 9)));
         cyc(n, $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
